q_span_scheduler: RTL and testbench
===================================

Name: q_span_scheduler

Overview:
- Sequences all accesses to the spline Q-weight table, which has one combinational read port and one write port.
- Arbitrates that single read port between filter-side span reads (output path) and update read-modify-writes (adaptation path).
- Buffers pending updates in a small FIFO and blocks filter reads that overlap a pending or in-flight write, so every read sees all earlier updates.

Parameters:
- WIDTH, 16, weight word width (signed two's complement)
- Q, 13, number of spans; legal span index 0..Q
- Q_ORD, 4, weights per span window
- FIFO_DEPTH, 4, pending-update FIFO entries (power of 2)
- STARVE_MAX, 8, cycles an update head may wait before it preempts reads
- IW (localparam), $clog2(Q+Q_ORD), span index width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rd_valid  in  1  filter read request
- rd_span  in  IW  filter read span index
- rd_ready  out  1  read accepted this cycle when high with rd_valid
- rd_data  out  Q_ORD*WIDTH  registered read weights, lane0 = lowest index
- rd_data_valid  out  1  one-cycle pulse, rd_data valid
- upd_valid  in  1  update request
- upd_span  in  IW  update span index
- upd_delta  in  Q_ORD*WIDTH  per-lane signed deltas
- upd_ready  out  1  FIFO not full
- flush  in  1  level; drain FIFO, block reads while high
- tbl_span_read  out  IW  table read address (combinational)
- tbl_weight_in  in  Q_ORD*WIDTH  table read data, same cycle
- tbl_we  out  1  table write strobe (registered)
- tbl_span_write  out  IW  table write span
- tbl_update_out  out  Q_ORD*WIDTH  new weights to write
- busy  out  1  FIFO non-empty or write stage occupied
- err  out  1  one-cycle pulse, illegal span dropped

Behaviour:
- Reset (reset low, async): FIFO empty, starve counter 0. rd_data=0, rd_data_valid=0, tbl_we=0, tbl_span_write=0, tbl_update_out=0, err=0, busy=0. rd_ready and upd_ready are forced to 0 while reset is low. A transaction in flight is discarded; no partial write occurs.
- Update push: happens on upd_valid && upd_ready.
  - upd_ready = !full; no bypass when full.
  - upd_span > Q: entry not pushed, err pulses the next cycle, upd_ready unaffected.
  - Push and pop in the same cycle are allowed at any fill level except push-when-full.
- Grant per cycle. The read port goes to exactly one of READ or UPD.
  - UPD wins if the FIFO is non-empty and any of these holds: full, starve_cnt >= STARVE_MAX, flush, or the head read is hazard-blocked.
  - Otherwise READ wins if rd_valid is high and there is no hazard.
  - Otherwise UPD wins if the FIFO is non-empty; else the port is idle (tbl_span_read holds the last value).
- Hazard: rd_span is blocked while |rd_span − s| < Q_ORD for any FIFO entry span s or for tbl_span_write with tbl_we=1.
  - rd_ready = grant READ && !flush && reset high.
  - rd_span > Q: rd_ready=1, read consumed, err pulses, no rd_data_valid.
- READ path:
  - Cycle N: tbl_span_read=rd_span.
  - Cycle N+1: rd_data = captured tbl_weight_in, rd_data_valid=1.
  - Latency is 1.
- UPD path (RMW):
  - Cycle N: tbl_span_read=head span; lane i new = tbl_weight_in[i] + upd_delta[i] (WIDTH-bit); FIFO pops.
  - Cycle N+1: tbl_we=1, with tbl_span_write and tbl_update_out registered.
  - The table updates at edge N+2.
  - Back-to-back UPD with overlapping spans: the second is stalled one cycle. The grant is withheld while the head overlaps the write-stage span, so the RMW always reads committed data.
- Starve counter: increments each cycle the FIFO is non-empty and UPD is not granted; clears on UPD grant or when the FIFO is empty.
- Flush: reads are blocked and updates drain at one per cycle, subject to the overlap stall. busy falls the cycle after the last tbl_we.
- busy = FIFO non-empty || tbl_we.

Optional Feature:
- Macro Q_SAT_EN.
- Defined: each lane add saturates to 0x7FFF / 0x8000 (for WIDTH=16) on signed overflow.
- Undefined: each lane add wraps modulo 2^WIDTH.

Test Plan:
- Table model at reset (lane values 0xE800 + 0x0400*k). Push span 6, deltas all 0x0100 → tbl_we one pulse: tbl_span_write=6, tbl_update_out lanes 0x0100, 0x0500, 0x0900, 0x0D00. A following read of span 6 → 0x0100, 0x0500, 0x0900, 0x0D00 (lane0 first).
- Pending update span 6; read span 8 → rd_ready=0 until that tbl_we commits. Read span 10 → rd_ready=1 immediately, rd_data_valid the next cycle.
- rd_valid held high continuously, one update pushed → UPD granted within STARVE_MAX+1 cycles, tbl_we no later than STARVE_MAX+2 cycles after the push.
- Weight lane 0x7F00 + delta 0x0200 → 0x7FFF with Q_SAT_EN, 0x8100 without. Likewise 0x8100 + 0xFE00 → 0x8000 with Q_SAT_EN, 0x7F00 without.
- Fill the FIFO (4 pushes, spans 0, 4, 8, 12) → upd_ready=0 on the 5th. Pushes of span 14 and a read of span 15 → err pulses, FIFO count unchanged.
- Assert flush with 3 entries pending, then pull reset low mid-drain → outputs are 0 asynchronously, busy=0. After reset release, no tbl_we occurs without a new push.

Source files
------------

// File: rtl/q_span_scheduler.sv
// Q-weight table port scheduler: arbitrates filter span reads against buffered update RMWs.
// Optional macro Q_SAT_EN: saturating lane adds (default build wraps modulo 2^WIDTH).
module q_span_scheduler #(
  parameter  int WIDTH      = 16,
  parameter  int Q          = 13,
  parameter  int Q_ORD      = 4,
  parameter  int FIFO_DEPTH = 4,
  parameter  int STARVE_MAX = 8,
  localparam int IW         = $clog2(Q + Q_ORD)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rd_valid,
  input  logic [IW-1:0]          rd_span,
  output logic                   rd_ready,
  output logic [Q_ORD*WIDTH-1:0] rd_data,
  output logic                   rd_data_valid,
  input  logic                   upd_valid,
  input  logic [IW-1:0]          upd_span,
  input  logic [Q_ORD*WIDTH-1:0] upd_delta,
  output logic                   upd_ready,
  input  logic                   flush,
  output logic [IW-1:0]          tbl_span_read,
  input  logic [Q_ORD*WIDTH-1:0] tbl_weight_in,
  output logic                   tbl_we,
  output logic [IW-1:0]          tbl_span_write,
  output logic [Q_ORD*WIDTH-1:0] tbl_update_out,
  output logic                   busy,
  output logic                   err
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [IW-1:0] SPAN_MAX   = IW'(Q);
  localparam logic [IW-1:0] WIN        = IW'(Q_ORD);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef struct packed {
    logic [IW-1:0]                 span;
    logic [Q_ORD-1:0][WIDTH-1:0]   delta;
  } upd_t;

  typedef enum logic [1:0] {G_IDLE, G_READ, G_UPD} grant_e;

  function automatic logic overlap(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [IW-1:0] d;
    d = (a >= b) ? a - b : b - a;
    return d < WIN;
  endfunction

  function automatic logic [WIDTH-1:0] lane_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
`ifdef Q_SAT_EN
    if (s[WIDTH] != s[WIDTH-1])
      return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    return s[WIDTH-1:0];
  endfunction

  upd_t                        fifo_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]       slot_vld_q, slot_vld_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               starve_q, starve_d;
  logic [IW-1:0]               addr_q;
  logic [IW-1:0]               wspan_q, wspan_d;
  logic [Q_ORD-1:0][WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d, new_w, win_w;
  logic                        we_q, we_d, rdv_q, rdv_d, err_q, err_d;

  upd_t   head, push_ent;
  grant_e grant;
  logic   fifo_ne, full, rd_legal, upd_legal, rd_hz, head_stall, push, pop, rd_fire;

  assign head      = fifo_q[rd_ptr_q];
  assign push_ent  = {upd_span, upd_delta};
  assign fifo_ne   = |slot_vld_q;
  assign full      = &slot_vld_q;
  assign rd_legal  = rd_span <= SPAN_MAX;
  assign upd_legal = upd_span <= SPAN_MAX;
  assign win_w     = tbl_weight_in;
  // The RMW must never read a window whose write is still sitting in the write stage.
  assign head_stall = we_q && overlap(head.span, wspan_q);

  always_comb begin
    rd_hz = we_q && overlap(rd_span, wspan_q);
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (slot_vld_q[i] && overlap(rd_span, fifo_q[i].span)) rd_hz = 1'b1;
    rd_hz = rd_hz && rd_legal;
  end

  always_comb begin
    grant = G_IDLE;
    if (fifo_ne && (full || starve_q >= STARVE_LIM || flush || (rd_valid && rd_hz)))
      grant = head_stall ? G_IDLE : G_UPD;
    else if (rd_valid && !rd_hz && !flush)
      grant = G_READ;
    else if (fifo_ne && !head_stall)
      grant = G_UPD;
  end

  assign rd_ready  = (grant == G_READ) && reset;
  assign upd_ready = !full && reset;
  assign push      = upd_valid && upd_ready && upd_legal;
  assign pop       = (grant == G_UPD);
  assign rd_fire   = rd_valid && rd_ready;

  always_comb begin
    tbl_span_read = addr_q;
    if (pop)                  tbl_span_read = head.span;
    else if (rd_fire && rd_legal) tbl_span_read = rd_span;
  end

  for (genvar g = 0; g < Q_ORD; g++) begin : g_lane
    assign new_w[g] = lane_add(win_w[g], head.delta[g]);
  end

  always_comb begin
    slot_vld_d = slot_vld_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (pop) begin
      slot_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d             = rd_ptr_q + PW'(1);
    end
    if (push) begin
      slot_vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    starve_d = starve_q;
    if (!fifo_ne || pop)            starve_d = '0;
    else if (starve_q < STARVE_LIM) starve_d = starve_q + CW'(1);
    we_d    = pop;
    wspan_d = pop ? head.span : wspan_q;
    wdata_d = pop ? new_w : wdata_q;
    rdv_d   = rd_fire && rd_legal;
    rdata_d = (rd_fire && rd_legal) ? win_w : rdata_q;
    err_d   = (upd_valid && upd_ready && !upd_legal) || (rd_fire && !rd_legal);
  end

  always_ff @(posedge clk)
    if (push) fifo_q[wr_ptr_q] <= push_ent;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      starve_q   <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wspan_q    <= '0;
      wdata_q    <= '0;
      rdv_q      <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      slot_vld_q <= slot_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      starve_q   <= starve_d;
      addr_q     <= tbl_span_read;
      we_q       <= we_d;
      wspan_q    <= wspan_d;
      wdata_q    <= wdata_d;
      rdv_q      <= rdv_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign rd_data        = rdata_q;
  assign rd_data_valid  = rdv_q;
  assign tbl_we         = we_q;
  assign tbl_span_write = wspan_q;
  assign tbl_update_out = wdata_q;
  assign busy           = fifo_ne || we_q;
  assign err            = err_q;
endmodule

// File: tb/tb_q_span_scheduler.sv
// Directed bench for q_span_scheduler with a behavioural weight table (word k resets to 0xE800+0x0400*k).
module tb_q_span_scheduler;
  localparam int IW = 5;
  localparam int LW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_valid, upd_valid, flush;
  logic [IW-1:0] rd_span, upd_span;
  logic [LW-1:0] upd_delta;
  logic          rd_ready, rd_data_valid, upd_ready, tbl_we, busy, err;
  logic [LW-1:0] rd_data, tbl_weight_in, tbl_update_out;
  logic [IW-1:0] tbl_span_read, tbl_span_write;

  logic [15:0] tbl [0:16];
  int n_tests = 0;
  int n_fail  = 0;
  int found;
  int hits;

  q_span_scheduler dut (
    .clk(clk), .reset(reset),
    .rd_valid(rd_valid), .rd_span(rd_span), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .upd_valid(upd_valid), .upd_span(upd_span), .upd_delta(upd_delta),
    .upd_ready(upd_ready), .flush(flush),
    .tbl_span_read(tbl_span_read), .tbl_weight_in(tbl_weight_in),
    .tbl_we(tbl_we), .tbl_span_write(tbl_span_write), .tbl_update_out(tbl_update_out),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always_comb begin
    tbl_weight_in = '0;
    for (int k = 0; k < 4; k++)
      if (int'(tbl_span_read) + k <= 16) tbl_weight_in[k*16 +: 16] = tbl[int'(tbl_span_read) + k];
  end

  always @(posedge clk)
    if (tbl_we)
      for (int k = 0; k < 4; k++)
        if (int'(tbl_span_write) + k <= 16) tbl[int'(tbl_span_write) + k] <= tbl_update_out[k*16 +: 16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i <= 16; i++) tbl[i] = 16'hE800 + 16'(16'h0400 * i);
    reset = 1'b0; flush = 1'b0;
    rd_valid = 1'b1; rd_span = 5'd3;
    upd_valid = 1'b1; upd_span = 5'd2; upd_delta = '0;
    #12;
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_upd_ready", upd_ready, 0);
    chk("rst_tbl_we", tbl_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_data_valid", rd_data_valid, 0);
    chk("rst_err", err, 0);
    rd_valid = 1'b0; upd_valid = 1'b0;
    @(negedge clk); reset = 1'b1;

    // basic RMW of span 6 then read it back
    upd_valid = 1'b1; upd_span = 5'd6; upd_delta = {4{16'h0100}};
    #1 chk("push_upd_ready", upd_ready, 1);
    cyc; upd_valid = 1'b0;
    #1 chk("rmw_read_addr", tbl_span_read, 6);
    chk("rmw_busy", busy, 1);
    cyc;
    chk("rmw_we", tbl_we, 1);
    chk("rmw_span", tbl_span_write, 6);
    chk("rmw_data", tbl_update_out, 64'h0D00_0900_0500_0100);
    cyc;
    chk("rmw_we_drop", tbl_we, 0);
    chk("rmw_busy_drop", busy, 0);
    rd_valid = 1'b1; rd_span = 5'd6;
    #1 chk("rd6_ready", rd_ready, 1);
    chk("rd6_addr", tbl_span_read, 6);
    cyc; rd_valid = 1'b0;
    chk("rd6_valid", rd_data_valid, 1);
    chk("rd6_data", rd_data, 64'h0D00_0900_0500_0100);
    cyc;
    chk("rd6_valid_pulse", rd_data_valid, 0);

    // overlapping read waits for the pending write to commit
    upd_valid = 1'b1; upd_span = 5'd6; upd_delta = '0;
    cyc; upd_valid = 1'b0;
    rd_valid = 1'b1; rd_span = 5'd8;
    #1 chk("hz_ready_fifo", rd_ready, 0);
    chk("hz_upd_addr", tbl_span_read, 6);
    cyc;
    #1 chk("hz_ready_wstage", rd_ready, 0);
    chk("hz_we", tbl_we, 1);
    cyc;
    #1 chk("hz_ready_clear", rd_ready, 1);
    cyc; rd_valid = 1'b0;
    chk("hz_rd_valid", rd_data_valid, 1);
    chk("hz_rd_data", rd_data, 64'h1400_1000_0D00_0900);

    // non-overlapping read proceeds past a pending update
    upd_valid = 1'b1; upd_span = 5'd6; upd_delta = '0;
    cyc; upd_valid = 1'b0;
    rd_valid = 1'b1; rd_span = 5'd10;
    #1 chk("nohz_ready", rd_ready, 1);
    chk("nohz_addr", tbl_span_read, 10);
    cyc; rd_valid = 1'b0;
    chk("nohz_rd_valid", rd_data_valid, 1);
    chk("nohz_rd_data", rd_data, 64'h1C00_1800_1400_1000);
    cyc;
    chk("nohz_we", tbl_we, 1);
    cyc;
    chk("nohz_idle", busy, 0);

    // continuous reads: the update still gets through after STARVE_MAX waits
    upd_valid = 1'b1; upd_span = 5'd0; upd_delta = '0;
    rd_valid = 1'b1; rd_span = 5'd10;
    cyc; upd_valid = 1'b0;
    found = 0;
    for (int k = 1; k <= 20 && found == 0; k++) begin
      if (tbl_we) found = k;
      else cyc;
    end
    chk("starve_we_cycle", found, 10);
    rd_valid = 1'b0;
    cyc; cyc;
    chk("starve_idle", busy, 0);

    // lane overflow: wrap by default, clamp with Q_SAT_EN
    tbl[4] = 16'h7F00; tbl[5] = 16'h8100;
    upd_valid = 1'b1; upd_span = 5'd4;
    upd_delta = {16'h0000, 16'h0000, 16'hFE00, 16'h0200};
    cyc; upd_valid = 1'b0;
    cyc;
    chk("ovf_we", tbl_we, 1);
`ifdef Q_SAT_EN
    chk("ovf_data", tbl_update_out, 64'h0500_0100_8000_7FFF);
`else
    chk("ovf_data", tbl_update_out, 64'h0500_0100_7F00_8100);
`endif
    cyc;

    // illegal spans are dropped with an err pulse
    upd_valid = 1'b1; upd_span = 5'd14; upd_delta = '0;
    #1 chk("bad_upd_ready", upd_ready, 1);
    cyc; upd_valid = 1'b0;
    chk("bad_upd_err", err, 1);
    chk("bad_upd_not_pushed", busy, 0);
    cyc;
    chk("bad_upd_err_pulse", err, 0);
    rd_valid = 1'b1; rd_span = 5'd15;
    #1 chk("bad_rd_ready", rd_ready, 1);
    cyc; rd_valid = 1'b0;
    chk("bad_rd_err", err, 1);
    chk("bad_rd_no_valid", rd_data_valid, 0);
    cyc;

    // fill the FIFO while illegal reads hold the port
    rd_valid = 1'b1; rd_span = 5'd15;
    for (int i = 0; i < 4; i++) begin
      upd_valid = 1'b1; upd_span = 5'(4 * i); upd_delta = '0;
      #1 chk("fill_upd_ready", upd_ready, 1);
      cyc;
    end
    upd_span = 5'd1;
    #1 chk("full_upd_ready", upd_ready, 0);
    chk("full_rd_ready", rd_ready, 0);
    chk("full_addr", tbl_span_read, 0);
    flush = 1'b1;
    cyc; upd_valid = 1'b0;
    #1 chk("flush_we", tbl_we, 1);
    chk("flush_busy", busy, 1);
    chk("flush_rd_ready", rd_ready, 0);
    #2 reset = 1'b0;
    #1;
    chk("areset_we", tbl_we, 0);
    chk("areset_busy", busy, 0);
    chk("areset_rd_data", rd_data, 0);
    chk("areset_upd_out", tbl_update_out, 0);
    chk("areset_span_write", tbl_span_write, 0);
    chk("areset_upd_ready", upd_ready, 0);
    rd_valid = 1'b0; flush = 1'b0;
    @(negedge clk); reset = 1'b1;
    hits = 0;
    for (int k = 0; k < 8; k++) begin
      cyc;
      if (tbl_we || busy) hits++;
    end
    chk("post_reset_quiet", hits, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
